// File: rtl/wb_arb2.sv
// wb_arb2: two-master classic Wishbone arbiter, round-robin on ties; define WB_ARB2_TIMEOUT_EN for the slave-ack watchdog.
module wb_arb2 #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic          m0_cyc,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  input  logic          m1_cyc,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_we,
  output logic          s_cyc,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nxt;
  logic last, last_nxt, own0, own1, cur_cyc, done, to;
  if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("wb_arb2: TIMEOUT must be within 2..1023");
  end
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign cur_cyc = own0 ? m0_cyc : own1 & m1_cyc;
  assign done = cur_cyc & s_ack;
`ifdef WB_ARB2_TIMEOUT_EN
  logic [9:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (own0 | own1) & !s_ack ? cnt + 10'd1 : '0;
      err <= err | to;
    end
  assign to = cur_cyc & !s_ack & (cnt == 10'(TIMEOUT - 1));
`else
  assign to = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
    end else begin
      state <= state_nxt;
      last <= last_nxt;
    end
  // a dropped cyc is an abort and leaves last untouched
  always_comb begin
    state_nxt = state;
    last_nxt = last;
    if (state == IDLE)
      state_nxt = m0_cyc & m1_cyc ? (last ? OWN0 : OWN1) : m0_cyc ? OWN0 : m1_cyc ? OWN1 : IDLE;
    else if (!cur_cyc)
      state_nxt = IDLE;
    else if (done | to) begin
      state_nxt = IDLE;
      last_nxt = own1;
    end
  end
  always_comb begin
    s_cyc = cur_cyc & !to;
    s_we = own0 ? m0_we : own1 & m1_we;
    s_addr = own0 ? m0_addr : own1 ? m1_addr : '0;
    s_wdata = own0 ? m0_wdata : own1 ? m1_wdata : '0;
    m0_ack = own0 & (done | to);
    m1_ack = own1 & (done | to);
    m0_rdata = to ? DW'(32'hDEADBEEF) : s_rdata;
    m1_rdata = to ? DW'(32'hDEADBEEF) : s_rdata;
  end
endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 Parameter AW, default 24, Wishbone address width.
REQ-002 Parameter DW, default 32, Wishbone data width.
REQ-003 Parameter TIMEOUT, default 64, slave-ack watchdog limit in clk cycles; legal range 2..1023.
REQ-004 clk  input  1  single clock; all logic in this domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 m0_addr/m1_addr  input  AW  master address.
REQ-007 m0_wdata/m1_wdata  input  DW  master write data.
REQ-008 m0_we/m1_we  input  1  master write enable.
REQ-009 m0_cyc/m1_cyc  input  1  master cycle request.
REQ-010 m0_ack/m1_ack  output  1  cycle termination to master.
REQ-011 m0_rdata/m1_rdata  output  DW  read data to master.
REQ-012 s_addr, s_wdata, s_we, s_cyc  output  AW/DW/1/1  shared slave bus.
REQ-013 s_rdata  input  DW; s_ack  input  1  slave response.
REQ-014 err  output  1  sticky watchdog-expired flag.

Function
REQ-015 FSM states IDLE, OWN0, OWN1; state and a 1-bit last-served flag (last) are registered.
REQ-016 IDLE: only m0_cyc -> OWN0; only m1_cyc -> OWN1; both -> owner is the master not equal to last; neither -> stay IDLE.
REQ-017 Grant latency: cyc sampled high in IDLE at edge N -> s_cyc high from cycle N+1.
REQ-018 In OWNx, s_addr/s_wdata/s_we/s_cyc are combinational copies of master x signals; in IDLE s_cyc=0, s_we=0, s_addr/s_wdata=0.
REQ-019 s_ack is routed combinationally to the owner's ack only; the non-owner's ack is 0 at all times.
REQ-020 s_rdata is driven to both m0_rdata and m1_rdata unmodified (except REQ-030).
REQ-021 On s_ack=1 in OWNx: next state IDLE, last<=x; one idle turnaround cycle always separates two grants.
REQ-022 Abort: owner drops cyc before s_ack -> next state IDLE, last unchanged, no ack issued.
REQ-023 s_ack received in IDLE is ignored; no ack forwarded.
REQ-024 A master's requests never reorder: one outstanding cycle per master, classic (non-pipelined) Wishbone only.
REQ-025 Starvation bound: a continuously requesting master is granted within one other master transaction plus 2 cycles.

Reset
REQ-026 rst=1 asynchronously forces state=IDLE, last=1 (m0 wins first tie), err=0, watchdog count=0.
REQ-027 During reset all outputs: s_cyc=0, s_we=0, m0_ack=m1_ack=0; reset mid-transaction abandons it with no ack.
REQ-028 First grant possible on the first clk edge after rst deasserts.

Configuration
REQ-029 Macro WB_ARB2_TIMEOUT_EN compiles in a watchdog counter, cleared in IDLE, incremented each cycle in OWNx without s_ack.
REQ-030 With macro: count reaching TIMEOUT-1 without s_ack -> owner ack=1 for one cycle, m0_rdata/m1_rdata=32'hDEADBEEF that cycle, s_cyc forced 0 that cycle, err<=1 (sticky until rst), next state IDLE, last<=owner.
REQ-031 Without macro: no counter logic, err tied 0, ownership held indefinitely until s_ack or abort.

Verification
REQ-032 m0_cyc=1 alone, write addr 0x000004 data 0x00FF00FF, slave acks 2 cycles after s_cyc -> s_cyc at N+1, s_addr/s_wdata match, m0_ack single pulse, m1_ack=0, IDLE one cycle after.
REQ-033 m0_cyc and m1_cyc asserted same edge after reset, both held -> order m0, m1, m0, m1; one IDLE cycle between each grant.
REQ-034 m1 owns, slave read returns 0x12345678 -> m1_rdata=0x12345678 with m1_ack=1, m0_ack stays 0.
REQ-035 m0 owns, m0_cyc dropped before s_ack -> IDLE next cycle, no acks, last unchanged; pending m1 granted next.
REQ-036 rst pulsed while OWN1 awaiting ack -> s_cyc=0 immediately (async), no ack after release, next tie grants m0.
REQ-037 With WB_ARB2_TIMEOUT_EN, TIMEOUT=8, slave never acks -> m0_ack pulse with rdata 0xDEADBEEF at 8th owned cycle, err=1 sticky; without macro, s_cyc held high indefinitely, err=0.
